// File: rtl/scroll_pkg.sv
// Shared types and character codes for the seven-segment message scroller.
// Codes match the downstream digit decoder.
package scroll_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SCROLL
  } state_e;

  localparam logic [3:0] BLANK_CODE = 4'hF;

  localparam logic [3:0] CHAR_O    = 4'd0;
  localparam logic [3:0] CHAR_T    = 4'd1;
  localparam logic [3:0] CHAR_DASH = 4'd2;
  localparam logic [3:0] CHAR_E    = 4'd3;
  localparam logic [3:0] CHAR_H    = 4'd4;
  localparam logic [3:0] CHAR_L    = 4'd7;
  localparam logic [3:0] CHAR_R    = 4'd8;

endpackage

// File: rtl/scroll_prescaler.sv
// Scroll-rate prescaler: counts 0..TICK_MAX-1 while run is high and
// strobes step on the terminal count.
module scroll_prescaler #(
  parameter int unsigned TICK_MAX = 50000000
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  input  logic hold_zero,
  output logic step
);

  localparam int unsigned CW = $clog2(TICK_MAX);

  logic [CW-1:0] cnt_q, cnt_d;

  assign step = run && (cnt_q == CW'(TICK_MAX - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (hold_zero) begin
      cnt_d = '0;
    end else if (step) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/scroll_msg_source.sv
// Loadable message source for the 4-digit scroller: stores a message in a ring
// buffer and emits a sliding 4-character window. Optional macro SCROLL_DIR_EN adds dir.
module scroll_msg_source
  import scroll_pkg::*;
#(
  parameter int unsigned       DEPTH    = 16,
  parameter int unsigned       CHAR_W   = 4,
  parameter int unsigned       TICK_MAX = 50000000,
  parameter logic [CHAR_W-1:0] BLANK    = CHAR_W'(BLANK_CODE)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [CHAR_W-1:0]      wr_char,
  input  logic                   wr_last,
  input  logic                   clear,
  input  logic                   enable,
`ifdef SCROLL_DIR_EN
  input  logic                   dir,
`endif
  output logic [CHAR_W-1:0]      digit3,
  output logic [CHAR_W-1:0]      digit2,
  output logic [CHAR_W-1:0]      digit1,
  output logic [CHAR_W-1:0]      digit0,
  output logic                   step_pulse,
  output logic [$clog2(DEPTH):0] msg_len
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  state_e            state_q, state_d;
  logic [LW-1:0]     len_q, len_d;
  logic [PW-1:0]     ptr_q, ptr_d, ptr_step;
  logic [CHAR_W-1:0] mem_q [DEPTH];
  logic [CHAR_W-1:0] dig_q [4];
  logic [CHAR_W-1:0] dig_d [4];
  logic              step_q;
  logic              store, tick, in_scroll;

  // (p + off) mod n for off <= 3 and p < n, without a divider.
  function automatic logic [PW-1:0] ring_idx(logic [PW-1:0] p, logic [1:0] off,
                                             logic [LW-1:0] n);
    logic [LW+1:0] i;
    i = (LW+2)'(p) + (LW+2)'(off);
    for (int k = 0; k < 3; k++) begin
      if (i >= (LW+2)'(n)) i = i - (LW+2)'(n);
    end
    return i[PW-1:0];
  endfunction

  assign in_scroll = (state_q == S_SCROLL);
  assign wr_ready  = !in_scroll;
  // A write coinciding with clear completes the handshake but is discarded.
  assign store     = wr_valid && wr_ready && !clear;

  scroll_prescaler #(
    .TICK_MAX (TICK_MAX)
  ) u_prescaler (
    .clock     (clock),
    .reset     (reset),
    .run       (in_scroll && enable && !clear),
    .hold_zero (!in_scroll || clear),
    .step      (tick)
  );

  always_comb begin
`ifdef SCROLL_DIR_EN
    if (dir) begin
      ptr_step = (ptr_q == '0) ? PW'(len_q - LW'(1)) : ptr_q - PW'(1);
    end else
`endif
    begin
      ptr_step = ((LW'(ptr_q) + LW'(1)) == len_q) ? '0 : ptr_q + PW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    ptr_d   = ptr_q;
    if (clear) begin
      state_d = S_IDLE;
      len_d   = '0;
      ptr_d   = '0;
    end else begin
      case (state_q)
        S_IDLE, S_LOAD: begin
          if (store) begin
            len_d = len_q + LW'(1);
            // A full buffer terminates the message even without wr_last.
            if (wr_last || (len_q == LW'(DEPTH - 1))) begin
              state_d = S_SCROLL;
              ptr_d   = '0;
            end else begin
              state_d = S_LOAD;
            end
          end
        end
        S_SCROLL: begin
          if (tick) ptr_d = ptr_step;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      dig_d[k] = BLANK;
      if (in_scroll && !clear) dig_d[k] = mem_q[ring_idx(ptr_d, 2'(3 - k), len_q)];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      ptr_q   <= '0;
      step_q  <= 1'b0;
      for (int k = 0; k < 4; k++) dig_q[k] <= BLANK;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      ptr_q   <= ptr_d;
      step_q  <= tick;
      for (int k = 0; k < 4; k++) dig_q[k] <= dig_d[k];
    end
  end

  always_ff @(posedge clock) begin
    if (store) mem_q[len_q[PW-1:0]] <= wr_char;
  end

  assign digit3     = dig_q[3];
  assign digit2     = dig_q[2];
  assign digit1     = dig_q[1];
  assign digit0     = dig_q[0];
  assign step_pulse = step_q;
  assign msg_len    = len_q;

endmodule

// File: tb/tb_scroll_msg_source.sv
// Directed bench for scroll_msg_source with TICK_MAX=4 and DEPTH=16.
module tb_scroll_msg_source;
  import scroll_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic       wr_valid, wr_last, clear, enable;
  logic [3:0] wr_char;
  logic       wr_ready, step_pulse;
  logic [3:0] digit3, digit2, digit1, digit0;
  logic [4:0] msg_len;
`ifdef SCROLL_DIR_EN
  logic       dir;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  scroll_msg_source #(
    .DEPTH    (16),
    .CHAR_W   (4),
    .TICK_MAX (4),
    .BLANK    (4'hF)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_char    (wr_char),
    .wr_last    (wr_last),
    .clear      (clear),
    .enable     (enable),
`ifdef SCROLL_DIR_EN
    .dir        (dir),
`endif
    .digit3     (digit3),
    .digit2     (digit2),
    .digit1     (digit1),
    .digit0     (digit0),
    .step_pulse (step_pulse),
    .msg_len    (msg_len)
  );

  always #5 clock = ~clock;

  wire [15:0] win = {digit3, digit2, digit1, digit0};

  typedef struct {
    logic [15:0] win;
    int          gap;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick1();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [3:0] c, input logic last);
    wr_valid = 1'b1;
    wr_char  = c;
    wr_last  = last;
    tick1();
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  // Bounded wait for the next step_pulse; returns cycles elapsed (20 on timeout).
  task automatic wait_step(output int cycles);
    cycles = 0;
    do begin
      tick1();
      cycles++;
    end while (!step_pulse && cycles < 20);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick1();
    tick1();
    reset = 1'b1;
  endtask

  task automatic load_hello();
    wr(CHAR_H, 1'b0);
    wr(CHAR_E, 1'b0);
    wr(CHAR_L, 1'b0);
    wr(CHAR_L, 1'b0);
    wr(CHAR_O, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    vecs[0] = '{win: 16'h3770, gap: 3};
    vecs[1] = '{win: 16'h7704, gap: 4};
    vecs[2] = '{win: 16'h7043, gap: 4};
    vecs[3] = '{win: 16'h0437, gap: 4};
    vecs[4] = '{win: 16'h4377, gap: 4};

    wr_valid = 0; wr_last = 0; clear = 0; enable = 1; wr_char = 0;
`ifdef SCROLL_DIR_EN
    dir = 0;
`endif
    do_reset();
    check("reset_digits", 32'(win), 32'hFFFF);
    check("reset_ready", 32'(wr_ready), 32'd1);
    check("reset_len", 32'(msg_len), 32'd0);
    check("reset_step", 32'(step_pulse), 32'd0);

    // HELLO-style message, forward scroll
    load_hello();
    check("hello_ready_low", 32'(wr_ready), 32'd0);
    check("hello_len", 32'(msg_len), 32'd5);
    check("hello_blank_on_entry", 32'(win), 32'hFFFF);
    tick1();
    check("hello_first_window", 32'(win), 32'h4377);
    for (int i = 0; i < 5; i++) begin
      wait_step(cyc);
      check($sformatf("hello_gap_%0d", i), 32'(cyc), 32'(vecs[i].gap));
      check($sformatf("hello_win_%0d", i), 32'(win), 32'(vecs[i].win));
    end

    // Freeze one cycle into the period; remaining count is 3 after re-enable
    tick1();
    enable = 1'b0;
    begin
      int seen = 0;
      for (int i = 0; i < 10; i++) begin
        tick1();
        if (step_pulse) seen++;
      end
      check("freeze_no_step", 32'(seen), 32'd0);
    end
    check("freeze_digits", 32'(win), 32'h4377);
    enable = 1'b1;
    wait_step(cyc);
    check("resume_gap", 32'(cyc), 32'd3);
    check("resume_win", 32'(win), 32'h3770);
    tick1();
    check("step_one_cycle", 32'(step_pulse), 32'd0);

    // Async reset mid-scroll
    reset = 1'b0;
    #2;
    check("async_rst_digits", 32'(win), 32'hFFFF);
    check("async_rst_ready", 32'(wr_ready), 32'd1);
    check("async_rst_len", 32'(msg_len), 32'd0);
    tick1();
    reset = 1'b1;

    // Full buffer auto-terminates; 17th write refused
    for (int i = 0; i < 16; i++) wr(4'(i), 1'b0);
    check("full_ready_low", 32'(wr_ready), 32'd0);
    check("full_len", 32'(msg_len), 32'd16);
    wr(4'd9, 1'b0);
    check("full_17th_len", 32'(msg_len), 32'd16);
    check("full_window", 32'(win), 32'h0123);
    wait_step(cyc);
    check("full_step_win", 32'(win), 32'h1234);

    // Clear with simultaneous transfer in LOAD
    do_reset();
    wr(4'd5, 1'b0);
    check("load_len", 32'(msg_len), 32'd1);
    wr_valid = 1'b1; wr_char = 4'd9; clear = 1'b1;
    tick1();
    wr_valid = 1'b0; clear = 1'b0;
    check("clear_len", 32'(msg_len), 32'd0);
    check("clear_ready", 32'(wr_ready), 32'd1);
    check("clear_digits", 32'(win), 32'hFFFF);

    // Short message repeats around the ring
    wr(4'd1, 1'b0);
    wr(4'd2, 1'b1);
    check("short_len", 32'(msg_len), 32'd2);
    tick1();
    check("short_window", 32'(win), 32'h1212);
    wait_step(cyc);
    check("short_gap", 32'(cyc), 32'd3);
    check("short_step_win", 32'(win), 32'h2121);

    // Clear from SCROLL blanks the next cycle
    clear = 1'b1;
    tick1();
    clear = 1'b0;
    check("scroll_clear_digits", 32'(win), 32'hFFFF);
    check("scroll_clear_ready", 32'(wr_ready), 32'd1);

`ifdef SCROLL_DIR_EN
    do_reset();
    dir = 1'b1;
    load_hello();
    tick1();
    check("dir_first_window", 32'(win), 32'h4377);
    wait_step(cyc);
    check("dir_step_win", 32'(win), 32'h0437);
    wait_step(cyc);
    check("dir_step2_win", 32'(win), 32'h7043);
    dir = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
